// File: rtl/slip_rx_framer.sv
// SLIP receive decoder: unescapes bytes, marks frame ends through a one-byte hold,
// enforces a maximum frame length and keeps saturating good/error frame counters.
module slip_rx_framer #(
  parameter int         MAX_LEN   = 1024,
  parameter int         LEN_W     = $clog2(MAX_LEN + 1),
  parameter int         CNT_W     = 16,
  parameter logic [7:0] END_B     = 8'hC0,
  parameter logic [7:0] ESC_B     = 8'hDB,
  parameter logic [7:0] ESC_END_B = 8'hDC,
  parameter logic [7:0] ESC_ESC_B = 8'hDD
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             out_err,
  output logic             frame_done,
  output logic [LEN_W-1:0] frame_len,
  output logic [1:0]       frame_err,
  input  logic             clear_stats,
  output logic [CNT_W-1:0] good_cnt,
  output logic [CNT_W-1:0] err_cnt
);

  typedef enum logic [1:0] {HUNT, DATA, ESCP, DISCARD} state_t;

  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [1:0] ERR_OK    = 2'b00;
  localparam logic [1:0] ERR_ESC   = 2'b01;
  localparam logic [1:0] ERR_LONG  = 2'b10;
  localparam logic [1:0] ERR_ABORT = 2'b11;

  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [7:0]         hold_reg, hold_next;
  logic               hold_full_reg, hold_full_next;

  logic [7:0]         out_data_reg;
  logic               out_valid_reg, out_last_reg, out_err_reg;
  logic               frame_done_reg;
  logic [LEN_W-1:0]   frame_len_reg;
  logic [1:0]         frame_err_reg;
  logic [CNT_W-1:0]   good_cnt_reg, err_cnt_reg;

  logic               accept;
  logic               push, push_last, push_err;
  logic               close;
  logic [LEN_W-1:0]   close_len;
  logic [1:0]         close_err;
  logic               dec_valid;
  logic [7:0]         dec_byte;

  assign accept = in_valid && (!out_valid_reg || out_ready);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= HUNT;
      len_reg       <= '0;
      hold_reg      <= '0;
      hold_full_reg <= 1'b0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      hold_reg      <= hold_next;
      hold_full_reg <= hold_full_next;
    end
  end

  // Next-state and push/close decisions
  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    hold_next      = hold_reg;
    hold_full_next = hold_full_reg;
    push           = 1'b0;
    push_last      = 1'b0;
    push_err       = 1'b0;
    close          = 1'b0;
    close_len      = len_reg;
    close_err      = ERR_OK;
    dec_valid      = 1'b0;
    dec_byte       = in_data;

    if (accept) begin
      unique case (state_reg)
        HUNT: begin
          if (in_data == END_B) begin
            state_next = DATA;
            len_next   = '0;
          end
        end
        DATA: begin
          if (in_data == END_B) begin
            if (len_reg != '0) begin
              push           = hold_full_reg;
              push_last      = 1'b1;
              close          = 1'b1;
              close_err      = ERR_OK;
              len_next       = '0;
              hold_full_next = 1'b0;
            end
          end else if (in_data == ESC_B) begin
            state_next = ESCP;
          end else begin
            dec_valid = 1'b1;
          end
        end
        ESCP: begin
          if (in_data == ESC_END_B) begin
            dec_valid  = 1'b1;
            dec_byte   = END_B;
            state_next = DATA;
          end else if (in_data == ESC_ESC_B) begin
            dec_valid  = 1'b1;
            dec_byte   = ESC_B;
            state_next = DATA;
          end else begin
            // Bad escape or abort: the END of an abort already opens the next frame.
            push           = hold_full_reg;
            push_last      = 1'b1;
            push_err       = 1'b1;
            close          = 1'b1;
            close_err      = (in_data == END_B) ? ERR_ABORT : ERR_ESC;
            state_next     = (in_data == END_B) ? DATA : DISCARD;
            len_next       = '0;
            hold_full_next = 1'b0;
          end
        end
        DISCARD: begin
          if (in_data == END_B) begin
            state_next = DATA;
            len_next   = '0;
          end
        end
        default: state_next = HUNT;
      endcase

      if (dec_valid) begin
        if (len_reg == MAX_LEN_L) begin
          push           = hold_full_reg;
          push_last      = 1'b1;
          push_err       = 1'b1;
          close          = 1'b1;
          close_err      = ERR_LONG;
          state_next     = DISCARD;
          len_next       = '0;
          hold_full_next = 1'b0;
        end else begin
          // The previous byte leaves the hold only once we know it is not the last.
          push           = hold_full_reg;
          hold_next      = dec_byte;
          hold_full_next = 1'b1;
          len_next       = len_reg + LEN_W'(1);
        end
      end
    end
  end

  // Output register, frame status and statistics
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data_reg   <= '0;
      out_valid_reg  <= 1'b0;
      out_last_reg   <= 1'b0;
      out_err_reg    <= 1'b0;
      frame_done_reg <= 1'b0;
      frame_len_reg  <= '0;
      frame_err_reg  <= '0;
      good_cnt_reg   <= '0;
      err_cnt_reg    <= '0;
    end else begin
      if (push) begin
        out_data_reg  <= hold_reg;
        out_valid_reg <= 1'b1;
        out_last_reg  <= push_last;
        out_err_reg   <= push_err;
      end else if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
        out_last_reg  <= 1'b0;
        out_err_reg   <= 1'b0;
      end

      frame_done_reg <= close;
      if (close) begin
        frame_len_reg <= close_len;
        frame_err_reg <= close_err;
      end

      if (clear_stats) begin
        good_cnt_reg <= '0;
        err_cnt_reg  <= '0;
      end else if (close) begin
        if (close_err == ERR_OK) begin
          if (good_cnt_reg != {CNT_W{1'b1}}) good_cnt_reg <= good_cnt_reg + CNT_W'(1);
        end else begin
          if (err_cnt_reg != {CNT_W{1'b1}}) err_cnt_reg <= err_cnt_reg + CNT_W'(1);
        end
      end
    end
  end

  // Output drive
  always_comb begin
    in_ready   = !out_valid_reg || out_ready;
    out_data   = out_data_reg;
    out_valid  = out_valid_reg;
    out_last   = out_last_reg;
    out_err    = out_err_reg;
    frame_done = frame_done_reg;
    frame_len  = frame_len_reg;
    frame_err  = frame_err_reg;
    good_cnt   = good_cnt_reg;
    err_cnt    = err_cnt_reg;
  end

endmodule

// File: tb/tb_slip_rx_framer.sv
// Directed bench for slip_rx_framer (MAX_LEN=4, CNT_W=4): per-byte vector table
// plus sequences for stats clear/saturation, reset mid-frame and output back-pressure.
module tb_slip_rx_framer;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] in_data;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       out_last;
  logic       out_err;
  logic       frame_done;
  logic [2:0] frame_len;
  logic [1:0] frame_err;
  logic       clear_stats;
  logic [3:0] good_cnt;
  logic [3:0] err_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  slip_rx_framer #(.MAX_LEN(4), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_last(out_last), .out_err(out_err),
    .frame_done(frame_done), .frame_len(frame_len), .frame_err(frame_err),
    .clear_stats(clear_stats), .good_cnt(good_cnt), .err_cnt(err_cnt)
  );

  typedef struct {
    logic [7:0] b;
    logic       ov;
    logic [7:0] d;
    logic       l;
    logic       e;
    logic       dn;
    logic [2:0] ln;
    logic [1:0] fe;
  } vec_t;

  vec_t vecs[64];
  int   nv = 0;

  task automatic add(input logic [7:0] b, input logic ov, input logic [7:0] d, input logic l,
                     input logic e, input logic dn, input logic [2:0] ln, input logic [1:0] fe);
    vecs[nv].b  = b;  vecs[nv].ov = ov; vecs[nv].d  = d;  vecs[nv].l  = l;
    vecs[nv].e  = e;  vecs[nv].dn = dn; vecs[nv].ln = ln; vecs[nv].fe = fe;
    nv++;
  endtask

  task automatic none(input logic [7:0] b);
    add(b, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 3'd0, 2'b00);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One accepted byte with out_ready held high; outputs are sampled 1 time unit after the edge.
  task automatic step(input logic [7:0] b, input logic clr);
    @(negedge clk);
    in_data     = b;
    in_valid    = 1'b1;
    clear_stats = clr;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    clear_stats = 1'b0;
  endtask

  logic [7:0] stream[14];
  logic [7:0] exp_d[8];
  logic       exp_l[8];
  logic [7:0] rx_d[8];
  logic       rx_l[8];

  initial begin
    rst = 1'b1; in_data = 8'h00; in_valid = 1'b0; out_ready = 1'b1; clear_stats = 1'b0;

    // C0 41 42 C0
    none(8'hC0); none(8'h41);
    add(8'h42, 1, 8'h41, 0, 0, 0, 3'd0, 2'b00);
    add(8'hC0, 1, 8'h42, 1, 0, 1, 3'd2, 2'b00);
    // C0 DB DC DB DD C0
    none(8'hC0); none(8'hDB); none(8'hDC); none(8'hDB);
    add(8'hDD, 1, 8'hC0, 0, 0, 0, 3'd0, 2'b00);
    add(8'hC0, 1, 8'hDB, 1, 0, 1, 3'd2, 2'b00);
    // C0 41 DB 55 42 C0 C0 43 C0
    none(8'hC0); none(8'h41); none(8'hDB);
    add(8'h55, 1, 8'h41, 1, 1, 1, 3'd1, 2'b01);
    none(8'h42); none(8'hC0); none(8'hC0); none(8'h43);
    add(8'hC0, 1, 8'h43, 1, 0, 1, 3'd1, 2'b00);
    // C0 01 02 03 04 05 06 C0 with MAX_LEN=4
    none(8'hC0); none(8'h01);
    add(8'h02, 1, 8'h01, 0, 0, 0, 3'd0, 2'b00);
    add(8'h03, 1, 8'h02, 0, 0, 0, 3'd0, 2'b00);
    add(8'h04, 1, 8'h03, 0, 0, 0, 3'd0, 2'b00);
    add(8'h05, 1, 8'h04, 1, 1, 1, 3'd4, 2'b10);
    none(8'h06); none(8'hC0);
    // C0 41 DB C0 42 C0
    none(8'hC0); none(8'h41); none(8'hDB);
    add(8'hC0, 1, 8'h41, 1, 1, 1, 3'd1, 2'b11);
    none(8'h42);
    add(8'hC0, 1, 8'h42, 1, 0, 1, 3'd1, 2'b00);
    // Bad escape on an empty frame: event without a byte
    none(8'hC0); none(8'hDB);
    add(8'h55, 0, 8'h00, 0, 0, 1, 3'd0, 2'b01);
    none(8'hC0);

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 8'h00);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_out_err", out_err, 1'b0);
    chk("rst_frame_done", frame_done, 1'b0);
    chk("rst_frame_len", frame_len, 3'd0);
    chk("rst_frame_err", frame_err, 2'b00);
    chk("rst_good_cnt", good_cnt, 4'd0);
    chk("rst_err_cnt", err_cnt, 4'd0);
    chk("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst = 1'b0;

    // Table-driven vectors
    for (int i = 0; i < nv; i++) begin
      step(vecs[i].b, 1'b0);
      $display("[TB] vec %0d in=%02h ov=%0b d=%02h last=%0b err=%0b done=%0b len=%0d ferr=%0b",
               i, vecs[i].b, out_valid, out_data, out_last, out_err, frame_done, frame_len, frame_err);
      chk($sformatf("vec%0d_out_valid", i), out_valid, vecs[i].ov);
      if (vecs[i].ov) begin
        chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].d);
        chk($sformatf("vec%0d_out_last", i), out_last, vecs[i].l);
        chk($sformatf("vec%0d_out_err", i), out_err, vecs[i].e);
      end
      chk($sformatf("vec%0d_frame_done", i), frame_done, vecs[i].dn);
      if (vecs[i].dn) begin
        chk($sformatf("vec%0d_frame_len", i), frame_len, vecs[i].ln);
        chk($sformatf("vec%0d_frame_err", i), frame_err, vecs[i].fe);
      end
    end
    chk("table_good_cnt", good_cnt, 4'd4);
    chk("table_err_cnt", err_cnt, 4'd4);

    // clear_stats coinciding with a good-frame close
    step(8'h77, 1'b0);
    step(8'hC0, 1'b1);
    $display("[TB] clear_stats at close: done=%0b good=%0d err=%0d", frame_done, good_cnt, err_cnt);
    chk("clr_frame_done", frame_done, 1'b1);
    chk("clr_good_cnt", good_cnt, 4'd0);
    chk("clr_err_cnt", err_cnt, 4'd0);

    // Saturation: 16 good frames into a 4-bit counter
    for (int i = 0; i < 16; i++) begin
      step(8'h88, 1'b0);
      step(8'hC0, 1'b0);
    end
    $display("[TB] saturation: good=%0d err=%0d", good_cnt, err_cnt);
    chk("sat_good_cnt", good_cnt, 4'd15);
    chk("sat_err_cnt", err_cnt, 4'd0);

    // Reset mid-frame
    step(8'h41, 1'b0);
    step(8'h42, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    $display("[TB] mid-frame reset: ov=%0b d=%02h good=%0d", out_valid, out_data, good_cnt);
    chk("mrst_out_valid", out_valid, 1'b0);
    chk("mrst_out_data", out_data, 8'h00);
    chk("mrst_frame_done", frame_done, 1'b0);
    chk("mrst_good_cnt", good_cnt, 4'd0);
    @(negedge clk);
    rst = 1'b0;
    step(8'h43, 1'b0);
    chk("mrst_hunt_drop", out_valid, 1'b0);
    step(8'hC0, 1'b0);
    chk("mrst_open_done", frame_done, 1'b0);
    step(8'h44, 1'b0);
    chk("mrst_hold", out_valid, 1'b0);
    step(8'hC0, 1'b0);
    $display("[TB] after reset frame: ov=%0b d=%02h last=%0b done=%0b len=%0d", out_valid, out_data, out_last, frame_done, frame_len);
    chk("mrst_out_data", out_data, 8'h44);
    chk("mrst_out_last", out_last, 1'b1);
    chk("mrst_frame_len", frame_len, 3'd1);
    chk("mrst_good_after", good_cnt, 4'd1);
    @(negedge clk);
    @(posedge clk);
    #1;

    // Back-pressure: three frames with random out_ready
    stream = '{8'hC0, 8'h11, 8'h22, 8'h33, 8'hC0, 8'h44, 8'hDB, 8'hDC, 8'hC0,
               8'h55, 8'hDB, 8'hDD, 8'h66, 8'hC0};
    exp_d  = '{8'h11, 8'h22, 8'h33, 8'h44, 8'hC0, 8'h55, 8'hDB, 8'h66};
    exp_l  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    begin
      int idx = 0;
      int rxn = 0;
      int cyc = 0;
      while ((idx < 14 || rxn < 8) && cyc < 1000) begin
        @(negedge clk);
        out_ready = 1'($urandom_range(0, 1));
        in_valid  = (idx < 14);
        in_data   = (idx < 14) ? stream[idx] : 8'h00;
        #1;
        chk($sformatf("bp_in_ready_c%0d", cyc), in_ready, !out_valid || out_ready);
        if (out_valid && out_ready) begin
          if (rxn < 8) begin
            rx_d[rxn] = out_data;
            rx_l[rxn] = out_last;
            $display("[TB] bp rx %0d: d=%02h last=%0b", rxn, out_data, out_last);
          end
          rxn++;
        end
        if (in_valid && in_ready) idx++;
        cyc++;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp_timeout", (cyc < 1000), 1'b1);
      chk("bp_rx_count", rxn, 8);
      for (int k = 0; k < 8; k++) begin
        if (k < rxn) begin
          chk($sformatf("bp_data%0d", k), rx_d[k], exp_d[k]);
          chk($sformatf("bp_last%0d", k), rx_l[k], exp_l[k]);
        end
      end
      @(posedge clk);
      #1;
      chk("bp_good_cnt", good_cnt, 4'd4);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
